key_debounce: RTL and testbench

// - Debounces a single-bit level that has already been registered by an upstream rising-edge D flip-flop.
//   The typical source is a push-button or switch.
// - Produces a clean level `q` plus optional one-cycle rise/fall strobes for downstream control logic.
// - Sits directly downstream of the input register stage and consumes its `q` output as `din`.

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_db_counter.sv | 33 +++
 rtl/key_debounce.sv | 124 ++++++++++++
 tb/tb_key_debounce.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared state encoding and default timing constants for the key_debounce block.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_IDLE_HIGH = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_e;

  // 20 ms at 50 MHz.
  localparam int unsigned STABLE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned CNT_W_DEFAULT         = 20;

endpackage

// File: rtl/key_debounce_db_counter.sv
// Stability counter: synchronous clear, load-1 and increment; flags the last qualifying count.
module db_counter #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load1_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load1_i) begin
      cnt_q <= CNT_W'(1);
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == CNT_W'(STABLE_CYCLES - 1));

endmodule

// File: rtl/key_debounce.sv
// Debouncer for a pre-registered level; q commits after STABLE_CYCLES equal samples.
// Define KEY_DEBOUNCE_EDGE_PULSE_EN to build the rise/fall strobe registers.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  state_e           state_q, state_d;
  logic             q_q, q_d;
  logic             cnt_clr, cnt_load1, cnt_inc, cnt_term;
  logic [CNT_W-1:0] cnt;

  db_counter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .load1_i(cnt_load1),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .term_o (cnt_term)
  );

  // NOTE: reset is synchronous, so it also wins over any transition decided in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE_LOW;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE_LOW: begin
        if (din) begin
          state_d   = ST_WAIT_HIGH;
          cnt_load1 = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (!din) begin
          state_d = ST_IDLE_LOW;
          cnt_clr = 1'b1;
        end else if (cnt_term) begin
          state_d = ST_IDLE_HIGH;
          q_d     = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_IDLE_HIGH: begin
        if (!din) begin
          state_d   = ST_WAIT_LOW;
          cnt_load1 = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        if (din) begin
          state_d = ST_IDLE_HIGH;
          cnt_clr = 1'b1;
        end else if (cnt_term) begin
          state_d = ST_IDLE_LOW;
          q_d     = 1'b0;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE_LOW;
    endcase
  end

  assign q = q_q;

`ifdef KEY_DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, rise_d, fall_q, fall_d;

  // A strobe fires exactly when a WAIT state commits to the opposite idle state.
  assign rise_d = (state_q == ST_WAIT_HIGH) && (state_d == ST_IDLE_HIGH);
  assign fall_d = (state_q == ST_WAIT_LOW)  && (state_d == ST_IDLE_LOW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce against a run-length reference model.
module tb_key_debounce;

  localparam int STABLE = 8;
`ifdef KEY_DEBOUNCE_EDGE_PULSE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic din;
  logic q, rise, fall;

  int checks = 0;
  int errors = 0;

  // Reference model: length of the current run of samples that differ from the committed level.
  int   m_run  = 0;
  logic m_q    = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int   rise_seen = 0;
  int   fall_seen = 0;

  key_debounce #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .q    (q),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic d, input logic r);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!r) begin
      m_q   = 1'b0;
      m_run = 0;
    end else if (d != m_q) begin
      m_run++;
      if (m_run == STABLE) begin
        m_q   = d;
        m_run = 0;
        if (EDGE_EN) begin
          m_rise = d;
          m_fall = ~d;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  // One clock: drive inputs, advance the model, compare #1 after the edge.
  task automatic step(input logic d, input logic r, input string name);
    din   = d;
    rst_n = r;
    @(posedge clk);
    model_edge(d, r);
    #1;
    checks++;
    if (q !== m_q) begin
      errors++;
      $display("FAIL %s q: got %b expected %b at %0t", name, q, m_q, $time);
    end
    checks++;
    if (rise !== m_rise || fall !== m_fall) begin
      errors++;
      $display("FAIL %s strobes: got rise=%b fall=%b expected rise=%b fall=%b at %0t",
               name, rise, fall, m_rise, m_fall, $time);
    end
    if (rise === 1'b1) rise_seen++;
    if (fall === 1'b1) fall_seen++;
  endtask

  task automatic hold(input logic d, input int n, input string name);
    for (int i = 0; i < n; i++) step(d, 1'b1, name);
  endtask

  task automatic expect_counts(input int exp_rise, input int exp_fall, input string name);
    checks++;
    if (rise_seen != exp_rise || fall_seen != exp_fall) begin
      errors++;
      $display("FAIL %s pulse count: got rise=%0d fall=%0d expected rise=%0d fall=%0d",
               name, rise_seen, fall_seen, exp_rise, exp_fall);
    end
    rise_seen = 0;
    fall_seen = 0;
  endtask

  task automatic expect_q(input logic exp, input string name);
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s final q: got %b expected %b", name, q, exp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset_hold");
    expect_q(1'b0, "reset_hold");
    hold(1'b1, STABLE - 1, "reset_release");
    expect_q(1'b0, "reset_release_7");
    hold(1'b1, 1, "reset_release");
    expect_q(1'b1, "reset_release_8");
    expect_counts(EDGE_EN ? 1 : 0, 0, "reset_release");
    hold(1'b0, STABLE, "reset_back_low");
    expect_q(1'b0, "reset_back_low");
    rise_seen = 0;
    fall_seen = 0;
  endtask

  task automatic test_press();
    hold(1'b0, 3, "press_idle");
    hold(1'b1, STABLE, "press");
    expect_q(1'b1, "press");
    expect_counts(EDGE_EN ? 1 : 0, 0, "press");
  endtask

  task automatic test_release();
    hold(1'b0, STABLE, "release");
    expect_q(1'b0, "release");
    expect_counts(0, EDGE_EN ? 1 : 0, "release");
  endtask

  task automatic test_bounce();
    hold(1'b1, 5, "bounce_hi");
    hold(1'b0, 1, "bounce_glitch");
    expect_q(1'b0, "bounce_glitch");
    expect_counts(0, 0, "bounce_glitch");
    hold(1'b1, STABLE, "bounce_settle");
    expect_q(1'b1, "bounce_settle");
    expect_counts(EDGE_EN ? 1 : 0, 0, "bounce_settle");
    hold(1'b0, STABLE, "bounce_back");
    rise_seen = 0;
    fall_seen = 0;
  endtask

  // Reversal after STABLE-1 equal samples, the latest point before commit.
  task automatic test_late_reversal();
    hold(1'b1, STABLE - 1, "late_rev_hi");
    hold(1'b0, 1, "late_rev_glitch");
    hold(1'b1, STABLE - 1, "late_rev_retry");
    expect_q(1'b0, "late_rev_retry");
    hold(1'b1, 1, "late_rev_commit");
    expect_q(1'b1, "late_rev_commit");
    hold(1'b0, STABLE - 1, "late_rev_lo");
    hold(1'b1, 1, "late_rev_glitch_lo");
    hold(1'b0, STABLE, "late_rev_fall");
    expect_q(1'b0, "late_rev_fall");
    expect_counts(EDGE_EN ? 1 : 0, EDGE_EN ? 1 : 0, "late_reversal");
  endtask

  task automatic test_reset_mid();
    hold(1'b1, 4, "rst_mid_hi");
    step(1'b1, 1'b0, "rst_mid_reset");
    hold(1'b1, STABLE - 1, "rst_mid_after");
    expect_q(1'b0, "rst_mid_after_7");
    hold(1'b1, 1, "rst_mid_after");
    expect_q(1'b1, "rst_mid_after_8");
    step(1'b0, 1'b0, "rst_from_high");
    expect_q(1'b0, "rst_from_high");
    hold(1'b0, 2, "rst_mid_settle");
    expect_counts(EDGE_EN ? 1 : 0, 0, "reset_mid");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, STABLE, "b2b_rise");
      hold(1'b0, STABLE, "b2b_fall");
    end
    expect_counts(EDGE_EN ? 3 : 0, EDGE_EN ? 3 : 0, "back_to_back");
  endtask

  task automatic test_random();
    logic lvl;
    int   len;
    for (int s = 0; s < 200; s++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, STABLE + 4));
      if ($urandom_range(0, 29) == 0) step(lvl, 1'b0, "rand_reset");
      hold(lvl, len, "random");
    end
  endtask

  initial begin
    din   = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_late_reversal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
